// File: rtl/brush_pkg.sv
// Shared types and constants for the brush stamp writer.
// BRUSH_ROUND_EN adds the disc-membership helper used by the round footprint.
package brush_pkg;

    localparam int unsigned H_PIXELS = 640;
    localparam int unsigned V_PIXELS = 360;
    localparam int unsigned ADDR_W   = 18;

    typedef logic [3:0] color_t;

    // Cursor snapshot: centre, colour and brush radius
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        color_t     color;
        logic [2:0] w;
    } stamp_t;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

`ifdef BRUSH_ROUND_EN
    // True when (px,py) lies inside the disc of radius w around (cx,cy).
    // Callers only pass pixels inside the clipped square, so |dx|,|dy| <= 7.
    function automatic logic in_disc(
        input logic [9:0] px,
        input logic [8:0] py,
        input logic [9:0] cx,
        input logic [8:0] cy,
        input logic [2:0] w
    );
        logic [2:0] dx;
        logic [2:0] dy;
        logic [5:0] dx2;
        logic [5:0] dy2;
        logic [5:0] w2;
        dx  = (px >= cx) ? 3'(px - cx) : 3'(cx - px);
        dy  = (py >= cy) ? 3'(py - cy) : 3'(cy - py);
        dx2 = {3'b000, dx} * {3'b000, dx};
        dy2 = {3'b000, dy} * {3'b000, dy};
        w2  = {3'b000, w} * {3'b000, w};
        return (7'(dx2) + 7'(dy2)) <= 7'(w2);
    endfunction
`endif

endpackage

// File: rtl/brush_bounds.sv
// Clips a brush footprint to the canvas and derives the first row base address.
module brush_bounds
    import brush_pkg::*;
(
    input  logic [9:0]        i_cx,
    input  logic [8:0]        i_cy,
    input  logic [2:0]        i_w,
    output logic [9:0]        o_x0,
    output logic [9:0]        o_x1,
    output logic [8:0]        o_y0,
    output logic [8:0]        o_y1,
    output logic [ADDR_W-1:0] o_base
);

    localparam logic signed [10:0] XMAX = 11'(H_PIXELS - 1);
    localparam logic signed [10:0] YMAX = 11'(V_PIXELS - 1);

    logic signed [10:0] w_r;
    logic signed [10:0] w_xl;
    logic signed [10:0] w_xh;
    logic signed [10:0] w_yl;
    logic signed [10:0] w_yh;

    assign w_r  = $signed({8'd0, i_w});
    assign w_xl = $signed({1'b0, i_cx}) - w_r;
    assign w_xh = $signed({1'b0, i_cx}) + w_r;
    assign w_yl = $signed({2'b00, i_cy}) - w_r;
    assign w_yh = $signed({2'b00, i_cy}) + w_r;

    assign o_x0 = (w_xl < 11'sd0) ? 10'd0 : w_xl[9:0];
    assign o_x1 = (w_xh > XMAX) ? XMAX[9:0] : w_xh[9:0];
    assign o_y0 = (w_yl < 11'sd0) ? 9'd0 : w_yl[8:0];
    assign o_y1 = (w_yh > YMAX) ? YMAX[8:0] : w_yh[8:0];

    // y0 * 640 as y0*512 + y0*128
    assign o_base = (ADDR_W'(o_y0) << 9) + (ADDR_W'(o_y0) << 7);

endmodule

// File: rtl/brush_stamp_writer.sv
// Per-frame brush stamp rasterizer: one frame-buffer write per covered pixel.
// Define BRUSH_ROUND_EN for a disc footprint; the default is a square.
module brush_stamp_writer
    import brush_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              nf_in,
    input  logic              pen_down_in,
    input  logic [9:0]        cursor_loc_x,
    input  logic [8:0]        cursor_loc_y,
    input  logic [3:0]        cursor_color,
    input  logic [2:0]        stroke_width,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [3:0]        fb_data_out,
    output logic              fb_valid_out,
    input  logic              fb_ready_in,
    output logic              busy_out,
    output logic              stamp_done_out
);

    state_t            r_state;
    stamp_t            r_pend;
    logic              r_pend_vld;
    logic [9:0]        r_x;
    logic [9:0]        r_x0;
    logic [9:0]        r_x1;
    logic [8:0]        r_y;
    logic [8:0]        r_y1;
    logic [ADDR_W-1:0] r_row_base;
`ifdef BRUSH_ROUND_EN
    logic [9:0]        r_cx;
    logic [8:0]        r_cy;
    logic [2:0]        r_w;
`endif

    stamp_t            w_live;
    stamp_t            w_src;
    logic [9:0]        w_x0;
    logic [9:0]        w_x1;
    logic [8:0]        w_y0;
    logic [8:0]        w_y1;
    logic [ADDR_W-1:0] w_base;
    logic              w_trig;
    logic              w_adv;
    logic              w_last_x;
    logic              w_last;
    logic              w_fin;
    logic              w_start;
    logic [9:0]        w_nx;
    logic [8:0]        w_ny;
    logic [ADDR_W-1:0] w_nbase;
    logic              w_in_first;
    logic              w_in_next;

    assign w_trig = nf_in && pen_down_in;
    assign w_live = '{x: cursor_loc_x, y: cursor_loc_y, color: cursor_color, w: stroke_width};
    // A fresh trigger beats an older pending snapshot
    assign w_src  = (r_pend_vld && !w_trig) ? r_pend : w_live;

    brush_bounds u_bounds (
        .i_cx   (w_src.x),
        .i_cy   (w_src.y),
        .i_w    (w_src.w),
        .o_x0   (w_x0),
        .o_x1   (w_x1),
        .o_y0   (w_y0),
        .o_y1   (w_y1),
        .o_base (w_base)
    );

    // Scan pointer step: advance when the presented pixel is taken or was skipped
    assign w_adv    = (r_state == SCAN) && (!fb_valid_out || fb_ready_in);
    assign w_last_x = (r_x == r_x1);
    assign w_last   = w_last_x && (r_y == r_y1);
    assign w_fin    = w_adv && w_last;
    assign w_start  = ((r_state == IDLE) && w_trig) || (w_fin && (w_trig || r_pend_vld));
    assign w_nx     = w_last_x ? r_x0 : r_x + 10'd1;
    assign w_ny     = w_last_x ? r_y + 9'd1 : r_y;
    assign w_nbase  = w_last_x ? r_row_base + ADDR_W'(H_PIXELS) : r_row_base;

`ifdef BRUSH_ROUND_EN
    assign w_in_first = in_disc(w_x0, w_y0, w_src.x, w_src.y, w_src.w);
    assign w_in_next  = in_disc(w_nx, w_ny, r_cx, r_cy, r_w);
`else
    assign w_in_first = 1'b1;
    assign w_in_next  = 1'b1;
`endif

    // Stamp FSM, pending slot and registered write-port outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state        <= IDLE;
            r_pend         <= '0;
            r_pend_vld     <= 1'b0;
            r_x            <= '0;
            r_x0           <= '0;
            r_x1           <= '0;
            r_y            <= '0;
            r_y1           <= '0;
            r_row_base     <= '0;
`ifdef BRUSH_ROUND_EN
            r_cx           <= '0;
            r_cy           <= '0;
            r_w            <= '0;
`endif
            fb_addr_out    <= '0;
            fb_data_out    <= '0;
            fb_valid_out   <= 1'b0;
            busy_out       <= 1'b0;
            stamp_done_out <= 1'b0;
        end else begin
            stamp_done_out <= w_fin;
            if ((r_state == SCAN) && w_trig) begin
                r_pend     <= w_live;
                r_pend_vld <= 1'b1;
            end
            if (w_start) begin
                r_state      <= SCAN;
                busy_out     <= 1'b1;
                r_pend_vld   <= 1'b0;
                r_x          <= w_x0;
                r_x0         <= w_x0;
                r_x1         <= w_x1;
                r_y          <= w_y0;
                r_y1         <= w_y1;
                r_row_base   <= w_base;
`ifdef BRUSH_ROUND_EN
                r_cx         <= w_src.x;
                r_cy         <= w_src.y;
                r_w          <= w_src.w;
`endif
                fb_addr_out  <= w_base + ADDR_W'(w_x0);
                fb_data_out  <= w_src.color;
                fb_valid_out <= w_in_first;
            end else if (w_fin) begin
                r_state      <= IDLE;
                busy_out     <= 1'b0;
                fb_valid_out <= 1'b0;
            end else if (w_adv) begin
                r_x          <= w_nx;
                r_y          <= w_ny;
                r_row_base   <= w_nbase;
                fb_addr_out  <= w_nbase + ADDR_W'(w_nx);
                fb_valid_out <= w_in_next;
            end
        end
    end

endmodule

// File: doc/brush_stamp_writer.md
Name: brush_stamp_writer

Overview:
- Consumes the cursor state produced by the user-input block: cursor_loc_x/y, cursor_color, stroke_width.
- Once per frame, while the pen is down, rasterizes a brush footprint centred on the cursor.
- Emits one frame-buffer write per covered pixel over a valid/ready interface to the canvas BRAM write port.
- Canvas is 640x360, 4-bit colour index per pixel, raster-addressed.

Parameters:
- H_PIXELS, 640, canvas width; also the row stride for addresses.
- V_PIXELS, 360, canvas height.
- ADDR_W, 18, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- nf_in  input  1  new-frame pulse, one cycle wide.
- pen_down_in  input  1  drawing enabled; sampled with nf_in.
- cursor_loc_x  input  10  cursor column, 0..639.
- cursor_loc_y  input  9  cursor row, 0..359.
- cursor_color  input  4  colour index to paint.
- stroke_width  input  3  brush radius w; footprint side is 2w+1.
- fb_addr_out  output  ADDR_W  pixel address, y*H_PIXELS + x.
- fb_data_out  output  4  colour to write.
- fb_valid_out  output  1  write request valid.
- fb_ready_in  input  1  frame buffer accepts the write.
- busy_out  output  1  stamp in progress.
- stamp_done_out  output  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, pending flag cleared. Reset is asynchronous, so fb_valid_out drops immediately even mid-stamp; a partial stamp is abandoned.
- Trigger: nf_in=1 and pen_down_in=1 in IDLE snapshots x, y, colour and w.
  - The snapshot is taken into internal registers; inputs may change freely afterwards.
  - Next cycle: FSM=SCAN, busy_out=1, first write presented. Latency from nf_in to first fb_valid_out is 1 cycle.
- Bounds, computed in signed 11-bit arithmetic:
  - x0 = max(0, cx-w), x1 = min(H_PIXELS-1, cx+w).
  - y0 = max(0, cy-w), y1 = min(V_PIXELS-1, cy+w).
  - Clipped pixels are never emitted; no wrap-around to adjacent rows.
- Scan order: raster, x innermost, from (x0,y0) to (x1,y1).
- Handshake:
  - While fb_valid_out=1, fb_addr_out and fb_data_out are held stable until a cycle with fb_ready_in=1.
  - A transfer occurs on a clock edge with valid&&ready.
  - Next pixel is presented the following cycle. Sustained throughput is 1 pixel/cycle when ready is held high.
  - fb_valid_out never depends combinationally on fb_ready_in.
- Address: fb_addr_out = y*H_PIXELS + x. Computed incrementally (row base += H_PIXELS per row) with no multiplier. Max value 230399.
- Completion:
  - On acceptance of pixel (x1,y1): stamp_done_out=1 for exactly 1 cycle, fb_valid_out=0, busy_out=0, FSM=IDLE.
  - A new trigger may start in that same IDLE cycle.
- nf_in while busy, with pen_down_in=1:
  - Snapshot goes into a one-deep pending slot; a later nf_in overwrites it (latest wins).
  - On completion, FSM goes directly to SCAN with the pending snapshot. busy_out stays 1 and stamp_done_out still pulses.
- nf_in with pen_down_in=0: ignored, no writes, pending slot untouched.
- w=0 produces exactly one write. Footprint size is (x1-x0+1)*(y1-y0+1) writes.

Optional Feature:
- Macro: BRUSH_ROUND_EN.
- Defined: the footprint is a disc. Pixel (x,y) is emitted only if (x-cx)^2 + (y-cy)^2 <= w^2, computed with unsigned 6-bit products.
  - Skipped pixels cost at most one cycle each with fb_valid_out=0.
  - Scan order, bounds and completion semantics are otherwise unchanged.
- Undefined: square footprint as above, no multiplier logic.

Decomposition:
- Shared package brush_pkg:
  - Constants H_PIXELS, V_PIXELS, ADDR_W.
  - typedef color_t (logic [3:0]).
  - typedef stamp_t: packed struct {x, y, color, w}, used for the snapshot and pending registers.
  - enum state_t {IDLE, SCAN}.
- Sub-module brush_bounds: combinational clip of the centre and radius to x0/x1/y0/y1 plus the starting row base (y0*H_PIXELS via shift-add). Instantiated once on the snapshot path.

Test Plan:
- (320,180), w=0, colour 5, nf pulse, ready=1 -> exactly one write, addr 115520, data 5; done pulse 2 cycles after nf.
- (0,0), w=1, ready=1 -> 4 writes, addrs 0, 1, 640, 641 in order; no negative or wrapped addresses.
- (638,359), w=2 -> 12 writes, first addr 229116, last 230399.
- w=1, ready toggling 1,0,0,1,... -> addr/data stable across stalls; all 9 addresses delivered once, in order.
- Three nf pulses during a 25-write stamp, last with (10,10) -> a second stamp at (10,10) starts immediately after done; the earlier pending snapshot is discarded. Then assert rst_in mid-stamp -> valid=0 asynchronously, no further writes.
- BRUSH_ROUND_EN, (100,100), w=2 -> 13 writes, excluding corners such as (98,98) and (102,101).
